alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational datapath ALU.
- Adds valid/ready handshakes on input and output, registered results and status flags, and a carry-in/carry-out path.
- Shifts are iterative, one bit per cycle; an optional iterative multiply is available.
- Sits between decode/register-file read and writeback; the controller stalls on InReady/OutValid.

Parameters:
- W, 8, datapath width in bits (>=2).
- Ops, 3, opcode width; encodings below are fixed for Ops=3.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- InValid  in  1  operands/opcode valid.
- InReady  out  1  block can accept a new operation.
- InputA  in  W  operand A.
- InputB  in  W  operand B (shift amount for shifts).
- OP  in  Ops  opcode.
- SC_in  in  1  carry-in for ADD.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- Out  out  W  registered result.
- Zero  out  1  ~|Out.
- Parity  out  1  ^Out.
- Odd  out  1  Out[0].
- Carry  out  1  carry/shift-out/overflow flag.
- Illegal  out  1  opcode not supported in this build.

Behaviour:
- Opcodes:
  - ADD=0: Out = A+B+SC_in; Carry = bit W of the sum.
  - XOR=1: Out = zero-extended ^B (reduction).
  - OR=2: A|B.
  - BGZ=3: Out = 1 if A>0 (unsigned) else 0.
  - SLL=4: logical left shift by B.
  - AND=5: A&B.
  - SRL=6: logical right shift by B.
  - MUL=7: optional, see below.
- For OR, AND, XOR and BGZ, Carry=0.
- Reset (async, Reset_n=0):
  - state=IDLE.
  - InReady=1, OutValid=0, Out=0, Zero=1, Parity=0, Odd=0, Carry=0, Illegal=0.
  - Any in-flight operation is aborted; no result is produced after release.
- States: IDLE, BUSY, DONE. InReady=1 only in IDLE.
- IDLE:
  - An operation is accepted on the edge where InValid&InReady.
  - Single-cycle ops go to DONE on that edge, Out and flags registered; latency 1.
  - Shift with effective count 0 goes to DONE; Out=A, Carry=0.
  - Shift with nonzero count goes to BUSY.
- BUSY (shift):
  - Effective count = min(B, W), captured at accept.
  - Each edge shifts the accumulator one bit (zero fill) and decrements the count.
  - Carry = last bit shifted out.
  - The edge that decrements the count to 0 goes to DONE. Latency = count edges.
  - Shift amount >= W gives Out=0; Carry = A[0] for SRL, A[W-1] for SLL.
- DONE:
  - OutValid=1. Out and flags are held stable until OutValid&OutReady, which returns to IDLE.
  - With OutReady held high, DONE lasts exactly one cycle.
  - No accept in the same cycle as result handoff; peak throughput is one op per 2 cycles.
- Operands are sampled only at accept. Changes on InputA, InputB or OP afterwards are ignored.
- Flags (Zero/Parity/Odd) are always consistent with Out, including at reset.
- Illegal: set in DONE for an unsupported opcode. Out=0, Carry=0, latency 1. Cleared on the next accept.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL=7 is an unsigned shift-add multiply.
  - Takes exactly W BUSY edges.
  - Out = low W bits of A*B.
  - Carry = |(high W bits), i.e. overflow.
  - Illegal=0.
- Undefined: MUL=7 is illegal (Illegal=1, Out=0, latency 1). No multiplier hardware is synthesised.

Decomposition:
- Package Definitions:
  - op_mne enum extended with SRL and MUL.
  - alu_state_t enum (IDLE, BUSY, DONE).
  - Localparam for the shift-count width, $clog2(W)+1.
- Sub-module alu_seq_flags: combinational Zero/Parity/Odd from a W-bit value, instantiated on the registered Out.

Test Plan (W=8):
- Reset then ADD A=8'hFF, B=8'h01, SC_in=1, OutReady=1 -> one cycle later OutValid=1, Out=8'h01, Carry=1, Zero=0, Odd=1; InReady back to 1 the next cycle.
- SLL A=8'h81, B=3 -> OutValid exactly 3 edges after accept, Out=8'h08, Carry=0 (bits shifted out 1,0,0; last shifted out = 0); SRL A=8'h81, B=9 -> Out=0, Carry=1, after 8 edges.
- BGZ A=0 -> Out=0, Zero=1; XOR B=8'h07 -> Out=8'h01, Parity=1; OR A=8'hF0, B=8'h0F -> Out=8'hFF, Parity=0.
- Output backpressure: ADD 3+4 with OutReady=0 for 5 cycles -> Out=7 held, OutValid=1, InReady=0 throughout; InValid pulses are ignored; handoff on the first OutReady=1.
- Reset_n low mid-shift (B=6, after 2 edges) -> outputs go to reset values immediately; after release, no stray OutValid.
- MUL A=8'h10, B=8'h11 -> with ALU_SEQ_MUL_EN: Out=8'h10, Carry=1, latency 8; without it: Illegal=1, Out=0, latency 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and state types plus sizing helpers shared by the sequential ALU.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      XOR = 3'd1,
      OR  = 3'd2,
      BGZ = 3'd3,
      SLL = 3'd4,
      AND = 3'd5,
      SRL = 3'd6,
      MUL = 3'd7
   } op_mne;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   localparam int unsigned ALU_W_DEF = 8;

   // Iteration counter must hold the full width W (saturated shift / multiply)
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

   localparam int unsigned ALU_CNT_W = cnt_width(ALU_W_DEF);

endpackage

// File: rtl/alu_seq_flags.sv
// alu_seq_flags: Zero/Parity/Odd status derived combinationally from a W-bit result.
module alu_seq_flags #(
   parameter int W = 8
) (
   input  logic [W-1:0] value,
   output logic         zero,
   output logic         parity,
   output logic         odd
);

   assign zero   = ~|value;
   assign parity = ^value;
   assign odd    = value[0];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and iterative one-bit-per-cycle shifts.
// Define ALU_SEQ_MUL_EN to build opcode MUL as a W-cycle shift-add multiplier; otherwise MUL is illegal.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W   = ALU_W_DEF,
   parameter int Ops = 3
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           InValid,
   output logic           InReady,
   input  logic [W-1:0]   InputA,
   input  logic [W-1:0]   InputB,
   input  logic [Ops-1:0] OP,
   input  logic           SC_in,
   output logic           OutValid,
   input  logic           OutReady,
   output logic [W-1:0]   Out,
   output logic           Zero,
   output logic           Parity,
   output logic           Odd,
   output logic           Carry,
   output logic           Illegal
);

   localparam int CNT_W = cnt_width(W);

   alu_state_t       state_r, state_nx_s;
   op_mne            op_s, op_r;
   logic             in_ready_r, out_valid_r;
   logic [W-1:0]     out_r, acc_r;
   logic             carry_r, illegal_r;
   logic [CNT_W-1:0] cnt_r;
   logic             sat_r, sat_carry_r;

   logic             accept_s, sat_s, multi_s;
   logic [CNT_W-1:0] eff_cnt_s, cnt_ld_s;
   logic [W-1:0]     acc_ld_s, imm_out_s, step_acc_s;
   logic             imm_carry_s, imm_ill_s, step_carry_s;
   logic [W:0]       sum_s;

`ifdef ALU_SEQ_MUL_EN
   logic [W-1:0]     hi_r, mcand_r;
   logic [W:0]       mul_sum_s;
   logic [W-1:0]     mul_hi_nx_s, mul_lo_nx_s;
`endif

   assign op_s      = op_mne'(OP);
   assign accept_s  = InValid & in_ready_r;
   assign sum_s     = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, SC_in};
   assign sat_s     = ({1'b0, InputB} >= (W+1)'(W));
   assign eff_cnt_s = sat_s ? CNT_W'(W) : InputB[CNT_W-1:0];

`ifdef ALU_SEQ_MUL_EN
   // Shift-add step: conditionally add multiplicand to the high half, then shift the pair right.
   assign mul_sum_s   = {1'b0, hi_r} + (acc_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
   assign mul_hi_nx_s = mul_sum_s[W:1];
   assign mul_lo_nx_s = {mul_sum_s[0], acc_r[W-1:1]};
`endif

   // Result of an accepted operation that completes on the accept edge.
   always_comb begin
      imm_out_s   = {W{1'b0}};
      imm_carry_s = 1'b0;
      imm_ill_s   = 1'b0;
      multi_s     = 1'b0;
      cnt_ld_s    = eff_cnt_s;
      acc_ld_s    = InputA;
      case (op_s)
         ADD: {imm_carry_s, imm_out_s} = sum_s;
         XOR: imm_out_s = {{(W-1){1'b0}}, ^InputB};
         OR:  imm_out_s = InputA | InputB;
         BGZ: imm_out_s = {{(W-1){1'b0}}, |InputA};
         AND: imm_out_s = InputA & InputB;
         SLL, SRL: begin
            if (eff_cnt_s == {CNT_W{1'b0}}) begin
               imm_out_s = InputA;
            end else begin
               multi_s = 1'b1;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         MUL: begin
            multi_s  = 1'b1;
            cnt_ld_s = CNT_W'(W);
            acc_ld_s = InputB;
         end
`endif
         default: imm_ill_s = 1'b1;
      endcase
   end

   // One BUSY iteration of the captured operation; carry is only meaningful on the last step.
   always_comb begin
      step_acc_s   = acc_r;
      step_carry_s = 1'b0;
      case (op_r)
         SLL: begin
            step_acc_s   = {acc_r[W-2:0], 1'b0};
            step_carry_s = sat_r ? sat_carry_r : acc_r[W-1];
         end
         SRL: begin
            step_acc_s   = {1'b0, acc_r[W-1:1]};
            step_carry_s = sat_r ? sat_carry_r : acc_r[0];
         end
`ifdef ALU_SEQ_MUL_EN
         MUL: begin
            step_acc_s   = mul_lo_nx_s;
            step_carry_s = |mul_hi_nx_s;
         end
`endif
         default: begin
            step_acc_s   = acc_r;
            step_carry_s = 1'b0;
         end
      endcase
   end

   // Next-state decode for the IDLE/BUSY/DONE handshake sequencer.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = multi_s ? BUSY : DONE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == CNT_W'(1)) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = BUSY;
            end
         end
         DONE: begin
            if (OutReady) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register with handshake outputs registered from the next state.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == DONE);
      end
   end

   // Operand capture, iteration and result/flag registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         op_r        <= ADD;
         acc_r       <= {W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         sat_r       <= 1'b0;
         sat_carry_r <= 1'b0;
         out_r       <= {W{1'b0}};
         carry_r     <= 1'b0;
         illegal_r   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         hi_r        <= {W{1'b0}};
         mcand_r     <= {W{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  op_r        <= op_s;
                  acc_r       <= acc_ld_s;
                  cnt_r       <= cnt_ld_s;
                  sat_r       <= sat_s;
                  // Saturated shifts report the first bit that leaves the word.
                  sat_carry_r <= (op_s == SRL) ? InputA[0] : InputA[W-1];
                  out_r       <= imm_out_s;
                  carry_r     <= imm_carry_s;
                  illegal_r   <= imm_ill_s;
`ifdef ALU_SEQ_MUL_EN
                  hi_r        <= {W{1'b0}};
                  mcand_r     <= InputA;
`endif
               end else begin
                  acc_r <= acc_r;
               end
            end
            BUSY: begin
               acc_r <= step_acc_s;
               cnt_r <= cnt_r - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
               hi_r  <= mul_hi_nx_s;
`endif
               if (cnt_r == CNT_W'(1)) begin
                  out_r   <= step_acc_s;
                  carry_r <= step_carry_s;
               end else begin
                  out_r   <= out_r;
               end
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

   alu_seq_flags #(.W(W)) u_flags (
      .value  (out_r),
      .zero   (Zero),
      .parity (Parity),
      .odd    (Odd)
   );

   assign InReady  = in_ready_r;
   assign OutValid = out_valid_r;
   assign Out      = out_r;
   assign Carry    = carry_r;
   assign Illegal  = illegal_r;

endmodule
